// File: rtl/hpdmc_idelay_seq.sv
// -----------------------------------------------------------------------------
// hpdmc_idelay_seq
//
// Tap-control sequencer for the 16-bit DQ IODELAY2 bank of the HPDMC PHY.
// Turns CSR commands (NOP / CAL / RST / MOVE) into correctly spaced
// single-cycle pulses on the shared CAL, RST, CE and INC pins. It also keeps a
// software-visible copy of the tap position, because the delay bank reports
// neither its position nor BUSY.
//
// Ports
//   sys_clk, sys_rst_n          clock (also the delay bank CLK), async active-low reset
//   cmd_valid / cmd_ready       command handshake; ready only while idle
//   cmd_op, cmd_dir, cmd_count  0=NOP 1=CAL 2=RST 3=MOVE; MOVE direction and step count
//   done                        one-cycle completion pulse, coincident with cmd_ready rising
//   sat                         sticky clip flag; cleared by the next accepted command
//   tap_pos                     tracked tap position
//   idly_cal/rst/ce/inc         delay bank control pins (all registered)
//
// Optional build macro: HPDMC_IDELAY_AUTOCAL_EN
//   When defined, a counter that advances only while idle self-issues a CAL
//   after AUTOCAL_PERIOD idle cycles. The CAL runs without a done pulse and
//   leaves sat alone. An external command on the terminal cycle wins.
// -----------------------------------------------------------------------------
module hpdmc_idelay_seq #(
    parameter int TAP_W    = 8,
    parameter int MAX_TAP  = 255,
    parameter int SETTLE   = 16,
    parameter int STEP_GAP = 2
`ifdef HPDMC_IDELAY_AUTOCAL_EN
    ,
    parameter int AUTOCAL_PERIOD = 65535
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [TAP_W-1:0] cmd_count,
    output logic             done,
    output logic             sat,
    output logic [TAP_W-1:0] tap_pos,
    output logic             idly_cal,
    output logic             idly_rst,
    output logic             idly_ce,
    output logic             idly_inc
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CAL  = 3'd1;
    localparam logic [2:0] S_RST  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_MOVE = 3'd4;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_CAL  = 2'd1;
    localparam logic [1:0] OP_RST  = 2'd2;
    localparam logic [1:0] OP_MOVE = 2'd3;

    localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [7:0]       GAP_M1    = 8'(STEP_GAP - 1);
    localparam logic [TAP_W-1:0] TAP_MAX   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);

    logic [2:0]       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] rem_q, rem_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             sat_q, sat_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             cal_q, cal_d;
    logic             rst_q, rst_d;
    logic             ce_q, ce_d;
    logic             inc_q, inc_d;

    logic             accept_s;
    logic             step_go_s;
    logic [TAP_W-1:0] step_rem_s;
    logic             step_dir_s;
    logic             at_lim_s;

`ifdef HPDMC_IDELAY_AUTOCAL_EN
    localparam int            AC_W  = $clog2(AUTOCAL_PERIOD + 1);
    localparam logic [AC_W-1:0] AC_TC = AC_W'(AUTOCAL_PERIOD - 1);
    logic [AC_W-1:0] ac_q, ac_d;
    logic            auto_q, auto_d;
    logic            ac_tc_s;
`endif

    // Next-state, tap tracking and registered-output computation.
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
        cal_d      = 1'b0;
        rst_d      = 1'b0;
        ce_d       = 1'b0;
        step_go_s  = 1'b0;
        step_rem_s = rem_q;
        step_dir_s = dir_q;
        accept_s   = cmd_valid & ready_q;
`ifdef HPDMC_IDELAY_AUTOCAL_EN
        ac_d    = ac_q;
        auto_d  = auto_q;
        ac_tc_s = (ac_q == AC_TC);
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    sat_d = 1'b0;
                    dir_d = cmd_dir;
`ifdef HPDMC_IDELAY_AUTOCAL_EN
                    auto_d = 1'b0;
                    ac_d   = ac_tc_s ? '0 : ac_q;
`endif
                    // NOP and zero-length moves finish on the accept edge, so
                    // done and cmd_ready appear together one cycle later.
                    case (cmd_op)
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                        OP_CAL: begin
                            state_d = S_CAL;
                            cal_d   = 1'b1;
                        end
                        OP_RST: begin
                            state_d = S_RST;
                            rst_d   = 1'b1;
                            tap_d   = '0;
                        end
                        OP_MOVE: begin
                            step_go_s  = 1'b1;
                            step_rem_s = cmd_count;
                            step_dir_s = cmd_dir;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
`ifdef HPDMC_IDELAY_AUTOCAL_EN
                else if (ac_tc_s) begin
                    state_d = S_CAL;
                    cal_d   = 1'b1;
                    auto_d  = 1'b1;
                    ac_d    = '0;
                end else begin
                    ac_d = ac_q + AC_W'(1);
                end
`else
                else begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_CAL, S_RST: begin
                state_d = S_WAIT;
                cnt_d   = SETTLE_M1;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
`ifdef HPDMC_IDELAY_AUTOCAL_EN
                    done_d  = ~auto_q;
`else
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_MOVE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    step_go_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One move slot: finish, clip, or emit a CE pulse. Shared by the
        // accept edge (first slot) and the end of every gap.
        at_lim_s = step_dir_s ? (tap_q == TAP_MAX) : (tap_q == '0);
        if (step_go_s) begin
            if (step_rem_s == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (at_lim_s) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                sat_d   = 1'b1;
            end else begin
                state_d = S_MOVE;
                ce_d    = 1'b1;
                tap_d   = step_dir_s ? (tap_q + TAP_ONE) : (tap_q - TAP_ONE);
                rem_d   = step_rem_s - TAP_ONE;
                gap_d   = GAP_M1;
            end
        end else begin
            ce_d = 1'b0;
        end

        inc_d   = (state_d == S_MOVE) ? dir_d : 1'b0;
        ready_d = (state_d == S_IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            rem_q   <= '0;
            gap_q   <= 8'd0;
            cnt_q   <= 8'd0;
            dir_q   <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            cal_q   <= 1'b0;
            rst_q   <= 1'b0;
            ce_q    <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            cal_q   <= cal_d;
            rst_q   <= rst_d;
            ce_q    <= ce_d;
            inc_q   <= inc_d;
        end
    end

`ifdef HPDMC_IDELAY_AUTOCAL_EN
    // Idle-time recalibration counter and self-issued-CAL marker.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ac_q   <= '0;
            auto_q <= 1'b0;
        end else begin
            ac_q   <= ac_d;
            auto_q <= auto_d;
        end
    end
`endif

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign sat       = sat_q;
    assign tap_pos   = tap_q;
    assign idly_cal  = cal_q;
    assign idly_rst  = rst_q;
    assign idly_ce   = ce_q;
    assign idly_inc  = inc_q;

endmodule
